// File: rtl/burst_pi_filter_pkg.sv
// Shared types and helpers for the colour-burst PI loop filter.
// Optional build macro: BURST_PI_AVG_EN (burst length normalisation).
package burst_pi_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_e;

  localparam int DEF_KP_SHIFT = 6;
  localparam int DEF_KI_SHIFT = 10;

  // Inputs must fit in 62 bits so the 64-bit sum cannot overflow before clamping.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s;
    logic signed [63:0] maxv;
    logic signed [63:0] minv;
    s    = a + b;
    maxv = (64'sd1 <<< (width - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (width - 1));
    if (s > maxv)      sat_add = maxv;
    else if (s < minv) sat_add = minv;
    else               sat_add = s;
  endfunction

  // Exponent of v rounded up to a power of two.
  function automatic int clog2_dyn(input int unsigned v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((32'd1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/burst_pi_filter_if.sv
// Burst-gate, error and NCO-offset signals of the burst PI loop filter.
// Optional build macro: BURST_PI_AVG_EN (affects burst_err scaling only).
interface burst_pi_filter_if #(
  parameter int ERR_W = 12,
  parameter int OUT_W = 16,
  parameter int ACC_W = 20
);
  logic                    burst_active;
  logic signed [ERR_W-1:0] error_in;
  logic                    freeze;
  logic signed [OUT_W-1:0] offset_out;
  logic                    update_valid;
  logic signed [ACC_W-1:0] burst_err;
  logic                    locked;

  modport master (
    output burst_active, error_in, freeze,
    input  offset_out, update_valid, burst_err, locked
  );

  modport slave (
    input  burst_active, error_in, freeze,
    output offset_out, update_valid, burst_err, locked
  );
endinterface

// File: rtl/burst_pi_filter_lock_detect.sv
// Lock detector: counts consecutive accepted lines whose burst error is small.
// Optional build macro: BURST_PI_AVG_EN (no effect here).
module burst_lock_detect #(
  parameter int ACC_W       = 20,
  parameter int LOCK_THRESH = 256,
  parameter int LOCK_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    update_i,
  input  logic                    clear_i,
  input  logic                    freeze_i,
  input  logic signed [ACC_W-1:0] burst_err_i,
  output logic                    locked_o
);
  localparam int CNT_W = $clog2(LOCK_LINES + 1);
  localparam logic [ACC_W:0]   THRESH_V = (ACC_W + 1)'(LOCK_THRESH);
  localparam logic [CNT_W-1:0] FULL_V   = CNT_W'(LOCK_LINES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] mag;
  logic             good;

  // Negating the most negative value yields its correct unsigned magnitude.
  assign mag  = burst_err_i[ACC_W-1] ? ACC_W'(-burst_err_i) : ACC_W'(burst_err_i);
  assign good = ({1'b0, mag} < THRESH_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (update_i && !freeze_i) begin
      if (!good)               cnt_d = '0;
      else if (cnt_q != FULL_V) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign locked_o = (cnt_q == FULL_V);
endmodule

// File: rtl/burst_pi_filter.sv
// Burst-window error accumulator feeding a once-per-line saturating PI controller.
// Optional build macro: BURST_PI_AVG_EN normalises each accepted burst to a nominal length.
module burst_pi_filter
  import burst_pi_pkg::*;
#(
  parameter int ERR_W       = 12,
  parameter int OUT_W       = 16,
  parameter int ACC_W       = 20,
  parameter int INT_W       = 32,
  parameter int KP_SHIFT    = DEF_KP_SHIFT,
  parameter int KI_SHIFT    = DEF_KI_SHIFT,
  parameter int MAX_SAMPLES = 127,
  parameter int MIN_SAMPLES = 8,
  parameter int LOCK_THRESH = 256,
  parameter int LOCK_LINES  = 16
) (
  input logic               clk,
  input logic               rst_n,
  burst_pi_filter_if.slave  bus
);
  localparam int CNT_W     = $clog2(MAX_SAMPLES + 1);
  localparam int AVG_SHIFT = CNT_W;
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_SAMPLES);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_SAMPLES);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] burst_err_q, burst_err_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [OUT_W-1:0] offset_q, offset_d;
  logic                    uv_q, uv_d;

  logic signed [ERR_W-1:0] err_s;
  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] accepted;
  logic signed [63:0]      isum64, i64, p64;
  logic                    upd, discard;

  assign err_s   = bus.error_in;
  assign err_ext = ACC_W'(err_s);

`ifdef BURST_PI_AVG_EN
  assign accepted = ACC_W'((64'(acc_q) <<< AVG_SHIFT) >>> clog2_dyn(32'(cnt_q)));
`else
  assign accepted = acc_q;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    burst_err_d = burst_err_q;
    integ_d     = integ_q;
    offset_d    = offset_q;
    uv_d        = 1'b0;
    upd         = 1'b0;
    discard     = 1'b0;
    isum64      = sat_add(64'(integ_q), 64'(burst_err_q), INT_W);
    i64         = (bus.freeze ? 64'(integ_q) : isum64) >>> KI_SHIFT;
    p64         = 64'(burst_err_q) >>> KP_SHIFT;
    case (state_q)
      IDLE: begin
        if (bus.burst_active) begin
          state_d = ACCUM;
          acc_d   = err_ext;
          cnt_d   = CNT_W'(1);
        end
      end
      ACCUM: begin
        if (bus.burst_active) begin
          if (cnt_q != MAX_V) begin
            acc_d = acc_q + err_ext;
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          acc_d = '0;
          cnt_d = '0;
          if (cnt_q >= MIN_V) begin
            burst_err_d = accepted;
            state_d     = UPDATE;
          end else begin
            discard = 1'b1;
            state_d = IDLE;
          end
        end
      end
      UPDATE: begin
        // A burst starting here is deliberately dropped; IDLE picks it up next cycle.
        state_d  = IDLE;
        upd      = 1'b1;
        uv_d     = 1'b1;
        integ_d  = bus.freeze ? integ_q : INT_W'(isum64);
        offset_d = OUT_W'(sat_add(p64, i64, OUT_W));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      burst_err_q <= '0;
      integ_q     <= '0;
      offset_q    <= '0;
      uv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
      integ_q     <= integ_d;
      offset_q    <= offset_d;
      uv_q        <= uv_d;
    end
  end

  burst_lock_detect #(
    .ACC_W      (ACC_W),
    .LOCK_THRESH(LOCK_THRESH),
    .LOCK_LINES (LOCK_LINES)
  ) u_lock (
    .clk        (clk),
    .rst_n      (rst_n),
    .update_i   (upd),
    .clear_i    (discard),
    .freeze_i   (bus.freeze),
    .burst_err_i(burst_err_q),
    .locked_o   (bus.locked)
  );

  assign bus.offset_out   = offset_q;
  assign bus.update_valid = uv_q;
  assign bus.burst_err    = burst_err_q;
endmodule

// File: tb/tb_burst_pi_filter.sv
// Directed, table-driven bench for burst_pi_filter: default, INT_W=20 and KI_SHIFT=0 builds.
// Assumes BURST_PI_AVG_EN is undefined (raw burst sums).
module tb_burst_pi_filter;
  logic clk;
  logic rst_n;
  logic ba;
  logic signed [11:0] err;
  logic frz;

  int nchecks = 0;
  int nerr    = 0;
  int sel     = 0;

  burst_pi_filter_if #(.ERR_W(12), .OUT_W(16), .ACC_W(20)) if0 ();
  burst_pi_filter_if #(.ERR_W(12), .OUT_W(16), .ACC_W(20)) if1 ();
  burst_pi_filter_if #(.ERR_W(12), .OUT_W(16), .ACC_W(20)) if2 ();

  assign if0.burst_active = ba;  assign if0.error_in = err;  assign if0.freeze = frz;
  assign if1.burst_active = ba;  assign if1.error_in = err;  assign if1.freeze = frz;
  assign if2.burst_active = ba;  assign if2.error_in = err;  assign if2.freeze = frz;

  burst_pi_filter dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  burst_pi_filter #(.INT_W(20)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  burst_pi_filter #(.KI_SHIFT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   o_off, o_be;
  logic o_uv, o_lk;
  always_comb begin
    o_off = int'(if0.offset_out); o_be = int'(if0.burst_err);
    o_uv  = if0.update_valid;     o_lk = if0.locked;
    case (sel)
      1: begin
        o_off = int'(if1.offset_out); o_be = int'(if1.burst_err);
        o_uv  = if1.update_valid;     o_lk = if1.locked;
      end
      2: begin
        o_off = int'(if2.offset_out); o_be = int'(if2.burst_err);
        o_uv  = if2.update_valid;     o_lk = if2.locked;
      end
      default: ;
    endcase
  end

  typedef struct {
    int dut;
    bit rst;
    int n;
    int val;
    bit frz;
    bit exp_uv;
    int exp_off;
    int exp_be;
    bit exp_lk;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(int dut, bit rst, int n, int val, bit f,
                              bit euv, int eoff, int ebe, bit elk);
    vec_t v;
    v.dut = dut; v.rst = rst; v.n = n; v.val = val; v.frz = f;
    v.exp_uv = euv; v.exp_off = eoff; v.exp_be = ebe; v.exp_lk = elk;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ba = 1'b0; err = '0; frz = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where burst_active was dropped.
  task automatic burst(int n, int v);
    for (int i = 0; i < n; i++) begin
      ba = 1'b1; err = 12'(v);
      @(negedge clk);
    end
    ba = 1'b0; err = '0;
  endtask

  initial begin
    int uvc;
    rst_n = 1'b1; ba = 1'b0; err = '0; frz = 1'b0;

    // Default build: gain path, MIN_SAMPLES boundary, counter saturation.
    add(0, 1, 32, 100, 0, 1, 53, 3200, 0);
    add(0, 0, 5, 500, 0, 0, 53, 3200, 0);
    add(0, 0, 8, 64, 0, 1, 11, 512, 0);
    add(0, 0, 7, 64, 0, 0, 11, 512, 0);
    add(0, 1, 200, 2047, 0, 1, 4315, 259969, 0);
    // Lock rises on the 16th good line, falls on a large error, freeze holds integrator.
    for (int i = 1; i <= 16; i++) add(0, i == 1, 10, 0, 0, 1, 0, 0, i == 16);
    add(0, 0, 10, 100, 0, 1, 15, 1000, 0);
    add(0, 0, 32, 100, 1, 1, 50, 3200, 0);
    add(0, 0, 32, 100, 0, 1, 54, 3200, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 10, 0, 0, 1, 4, 0, i == 16);
    add(0, 0, 5, 500, 0, 0, 4, 0, 0);
    // INT_W=20: integrator clamps at 524287 and recovers immediately.
    add(1, 1, 130, 2047, 0, 1, 4315, 259969, 0);
    add(1, 0, 130, 2047, 0, 1, 4569, 259969, 0);
    add(1, 0, 130, 2047, 0, 1, 4573, 259969, 0);
    add(1, 0, 130, 2047, 0, 1, 4573, 259969, 0);
    add(1, 0, 127, -2048, 0, 1, -3807, -260096, 0);
    // KI_SHIFT=0: output saturation in both directions.
    add(2, 1, 130, 2047, 0, 1, 32767, 259969, 0);
    add(2, 0, 127, -2048, 0, 1, -4191, -260096, 0);
    add(2, 0, 127, -2048, 0, 1, -32768, -260096, 0);

    do_reset();
    sel = 0;
    chk("reset_offset", o_off, 0);
    chk("reset_uv", int'(o_uv), 0);
    chk("reset_burst_err", o_be, 0);
    chk("reset_locked", int'(o_lk), 0);

    foreach (vecs[k]) begin
      sel = vecs[k].dut;
      if (vecs[k].rst) do_reset();
      frz = vecs[k].frz;
      burst(vecs[k].n, vecs[k].val);
      @(negedge clk);
      chk($sformatf("v%0d_uv_at_E", k), int'(o_uv), 0);
      @(negedge clk);
      chk($sformatf("v%0d_uv", k), int'(o_uv), int'(vecs[k].exp_uv));
      chk($sformatf("v%0d_offset", k), o_off, vecs[k].exp_off);
      chk($sformatf("v%0d_burst_err", k), o_be, vecs[k].exp_be);
      chk($sformatf("v%0d_locked", k), int'(o_lk), int'(vecs[k].exp_lk));
      frz = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_uv_after", k), int'(o_uv), 0);
      $display("vec %0d dut%0d n=%0d err=%0d frz=%0d -> uv=%0d off=%0d be=%0d lk=%0d",
               k, vecs[k].dut, vecs[k].n, vecs[k].val, vecs[k].exp_uv ? 1 : 0,
               o_uv, o_off, o_be, o_lk);
    end

    // Burst starting during UPDATE: its first sample (1000) must be dropped.
    sel = 0;
    do_reset();
    burst(10, 100);
    @(negedge clk);
    ba = 1'b1; err = 12'sd1000;
    @(negedge clk);
    chk("upd_rise_first_uv", int'(o_uv), 1);
    chk("upd_rise_first_offset", o_off, 15);
    burst(8, 100);
    repeat (2) @(negedge clk);
    chk("upd_rise_uv", int'(o_uv), 1);
    chk("upd_rise_burst_err", o_be, 800);
    chk("upd_rise_offset", o_off, 13);
    $display("seq update-rise: be=%0d off=%0d", o_be, o_off);

    // Freeze without burst activity changes nothing.
    frz = 1'b1;
    uvc = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_uv) uvc++;
    end
    frz = 1'b0;
    chk("idle_freeze_uv_count", uvc, 0);
    chk("idle_freeze_offset", o_off, 13);
    chk("idle_freeze_burst_err", o_be, 800);
    $display("seq idle-freeze: uv_count=%0d off=%0d", uvc, o_off);

    // Reset mid-burst abandons the partial sum.
    burst(20, 500);
    ba = 1'b1; err = 12'sd500;
    rst_n = 1'b0;
    #1;
    chk("midrst_offset", o_off, 0);
    chk("midrst_burst_err", o_be, 0);
    @(negedge clk);
    ba = 1'b0; err = '0;
    rst_n = 1'b1;
    uvc = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_uv) uvc++;
    end
    chk("midrst_uv_count", uvc, 0);
    chk("midrst_offset_after", o_off, 0);
    $display("seq mid-reset: uv_count=%0d off=%0d", uvc, o_off);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
